// File: rtl/rv32_dma_pkg.sv
// Shared types and constants for the rv32 block-copy DMA engine.
// Holds the FSM encoding, word size and default parameter values.
package rv32_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

    localparam int DMA_WORD_BYTES    = 4;
    localparam int DMA_DEF_BURST_LEN = 4;
    localparam int DMA_DEF_LEN_W     = 16;

endpackage

// File: rtl/rv32_dma_buf.sv
// Burst staging FIFO: DEPTH x 32-bit words, synchronous push/pop, flush wins.
// Data storage is not reset; only the pointers and occupancy count are.
module rv32_dma_buf
    import rv32_dma_pkg::*;
#(
    parameter int DEPTH = DMA_DEF_BURST_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] wr_data,
    output logic        full,
    output logic        empty,
    output logic [31:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wr_data;
    end

    // The engine only fills in RD and only drains in WR, so both at once is a bug.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && pop));

endmodule

// File: rtl/rv32_dma_engine.sv
// Block-copy DMA initiator: reads bursts of words into a staging FIFO, writes
// them back to the destination, and raises a level irq on completion or error.
module rv32_dma_engine
    import rv32_dma_pkg::*;
#(
    parameter int BURST_LEN = DMA_DEF_BURST_LEN,
    parameter int LEN_W     = DMA_DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_src,
    input  logic [31:0]      cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_abort,
    input  logic             irq_clr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             irq,
    output logic             dma_req,
    output logic [31:0]      dma_addr,
    output logic [31:0]      dma_wdata,
    output logic             dma_we,
    input  logic [31:0]      dma_rdata,
    input  logic             dma_grant
);

    localparam int BC_W = $clog2(BURST_LEN) + 1;

    dma_state_e       state, state_nxt;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] remaining;
    logic [BC_W-1:0]  beat_cnt;
    logic [BC_W-1:0]  burst_q;

    logic        start_acc;
    logic        misaligned;
    logic        active;
    logic        rd_beat;
    logic        wr_beat;
    logic        last_beat;
    logic        buf_full;
    logic        buf_empty;
    logic [31:0] buf_head;

    function automatic logic [BC_W-1:0] burst_of(input logic [LEN_W-1:0] n);
        if (n >= LEN_W'(BURST_LEN)) return BC_W'(BURST_LEN);
        return n[BC_W-1:0];
    endfunction

    assign start_acc  = (state == ST_IDLE) && cfg_start;
    assign misaligned = (cfg_src[1:0] != 2'b00) || (cfg_dst[1:0] != 2'b00);
    assign active     = (state != ST_IDLE);
    assign rd_beat    = (state == ST_RD) && dma_grant;
    assign wr_beat    = (state == ST_WR) && dma_grant;
    assign last_beat  = (beat_cnt == BC_W'(1));

    rv32_dma_buf #(.DEPTH(BURST_LEN)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (rd_beat && !buf_full),
        .pop     (wr_beat && !buf_empty),
        .flush   (cfg_abort && active),
        .wr_data (dma_rdata),
        .full    (buf_full),
        .empty   (buf_empty),
        .head    (buf_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start && !misaligned)
                    state_nxt = (cfg_len == '0) ? ST_DONE : ST_RD;
            end
            ST_RD: begin
                if (cfg_abort)                 state_nxt = ST_IDLE;
                else if (rd_beat && last_beat) state_nxt = ST_WR;
            end
            ST_WR: begin
                if (cfg_abort) state_nxt = ST_IDLE;
                else if (wr_beat && last_beat)
                    state_nxt = (remaining == LEN_W'(1)) ? ST_DONE : ST_RD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = active;
        done      = (state == ST_DONE) && !cfg_abort;
        dma_req   = (state == ST_RD) || (state == ST_WR);
        dma_we    = (state == ST_WR);
        dma_addr  = '0;
        dma_wdata = '0;
        if (state == ST_RD) dma_addr = src_ptr;
        if (state == ST_WR) begin
            dma_addr  = dst_ptr;
            dma_wdata = buf_head;
        end
    end

    // beat_cnt counts the current burst twice: once down in RD, reloaded, once down in WR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            burst_q   <= '0;
            err       <= 1'b0;
        end else if (start_acc) begin
            src_ptr   <= cfg_src;
            dst_ptr   <= cfg_dst;
            remaining <= cfg_len;
            beat_cnt  <= burst_of(cfg_len);
            burst_q   <= burst_of(cfg_len);
            err       <= misaligned;
        end else if (rd_beat) begin
            src_ptr  <= src_ptr + 32'(DMA_WORD_BYTES);
            beat_cnt <= last_beat ? burst_q : beat_cnt - 1'b1;
        end else if (wr_beat) begin
            dst_ptr   <= dst_ptr + 32'(DMA_WORD_BYTES);
            remaining <= remaining - 1'b1;
            if (last_beat) begin
                beat_cnt <= burst_of(remaining - 1'b1);
                burst_q  <= burst_of(remaining - 1'b1);
            end else begin
                beat_cnt <= beat_cnt - 1'b1;
            end
        end
    end

    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 irq <= 1'b0;
        else if (start_acc && misaligned)           irq <= 1'b1;
        else if ((state == ST_DONE) && !cfg_abort)  irq <= 1'b1;
        else if (irq_clr)                           irq <= 1'b0;
    end

endmodule

// File: tb/tb_rv32_dma_engine.sv
// Directed scoreboard bench for rv32_dma_engine: expected bus beats and done
// cycles are queued by the stimulus and consumed by a concurrent monitor.
module tb_rv32_dma_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [31:0] cfg_src;
    logic [31:0] cfg_dst;
    logic [15:0] cfg_len;
    logic        cfg_abort;
    logic        irq_clr;
    logic        busy, done, err, irq;
    logic        dma_req, dma_we, dma_grant;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    int          done_q[$];
    logic [31:0] mem [1024];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          gmode = 0;
    logic        req_seen = 1'b0;
    logic        poke_en = 1'b0;
    logic [31:0] poke_a = '0;
    logic [31:0] poke_d = '0;
    int          e;

    rv32_dma_engine #(.BURST_LEN(4), .LEN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_src   (cfg_src),
        .cfg_dst   (cfg_dst),
        .cfg_len   (cfg_len),
        .cfg_abort (cfg_abort),
        .irq_clr   (irq_clr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .irq       (irq),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_we    (dma_we),
        .dma_rdata (dma_rdata),
        .dma_grant (dma_grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign dma_rdata = mem[dma_addr[11:2]];

    always @(posedge clk) begin
        if (poke_en)                              mem[poke_a[11:2]] <= poke_d;
        else if (dma_req && dma_grant && dma_we)  mem[dma_addr[11:2]] <= dma_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        poke_a  = a;
        poke_d  = d;
        poke_en = 1'b1;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic push_beat(input logic we, input logic [31:0] a, input logic [31:0] d);
        beat_t b;
        b.we = we; b.addr = a; b.data = d;
        exp_q.push_back(b);
    endtask

    task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                         output int edge_e);
        cfg_src   = s;
        cfg_dst   = d;
        cfg_len   = l;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        edge_e    = cyc;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_after_clr", {31'd0, irq}, 32'd0);
    endtask

    task automatic grant_driver();
        logic tog = 1'b0;
        dma_grant = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tog = ~tog;
            dma_grant = (gmode == 0) ? 1'b1 : (gmode == 1) ? tog : 1'b0;
        end
    endtask

    task automatic monitor();
        beat_t       b;
        logic        pend = 1'b0;
        logic [31:0] pend_addr = '0;
        logic [31:0] pend_data = '0;
        int          de;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                continue;
            end
            if (dma_req) req_seen = 1'b1;
            if (pend) begin
                chk("stall_req", {31'd0, dma_req}, 32'd1);
                chk("stall_addr", dma_addr, pend_addr);
                chk("stall_wdata", dma_wdata, pend_data);
            end
            pend      = dma_req && !dma_grant;
            pend_addr = dma_addr;
            pend_data = dma_wdata;
            if (dma_req && dma_grant) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat_unexpected: we=%0b addr=%h, required no beat", dma_we, dma_addr);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_we", {31'd0, dma_we}, {31'd0, b.we});
                    chk("beat_addr", dma_addr, b.addr);
                    if (b.we) chk("beat_wdata", dma_wdata, b.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected: done=1 at cycle %0d, required 0", cyc);
                end else begin
                    de = done_q.pop_front();
                    if (de >= 0) chk("done_cycle", cyc, de);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
        cfg_abort = 1'b0; irq_clr = 1'b0;
        fork
            grant_driver();
            monitor();
        join_none

        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_req", {31'd0, dma_req}, 32'd0);
        chk("rst_we", {31'd0, dma_we}, 32'd0);
        chk("rst_addr", dma_addr, 32'd0);
        chk("rst_wdata", dma_wdata, 32'd0);
        for (int i = 0; i < 6; i++) poke(32'h400 + 32'(4 * i), 32'(i + 1));
        rst_n = 1'b1;
        tick();

        // Basic copy, grant always high: done in cycle E+9 (monitor cyc == E+8).
        for (int i = 0; i < 4; i++) push_beat(1'b0, 32'h400 + 32'(4 * i), 32'd0);
        for (int i = 0; i < 4; i++) push_beat(1'b1, 32'h500 + 32'(4 * i), 32'(i + 1));
        start(32'h400, 32'h500, 16'd4, e);
        done_q.push_back(e + 8);
        chk("basic_req_after_start", {31'd0, dma_req}, 32'd1);
        while (cyc < e + 8) tick();
        chk("basic_irq_in_done", {31'd0, irq}, 32'd0);
        tick();
        chk("basic_irq_set", {31'd0, irq}, 32'd1);
        chk("basic_busy_end", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) chk("basic_mem", mem[(32'h500 >> 2) + i], 32'(i + 1));
        clear_irq();

        // Two bursts (4 + 2) with grant toggling.
        gmode = 1;
        tick();
        for (int i = 0; i < 4; i++) push_beat(1'b0, 32'h400 + 32'(4 * i), 32'd0);
        for (int i = 0; i < 4; i++) push_beat(1'b1, 32'h500 + 32'(4 * i), 32'(i + 1));
        push_beat(1'b0, 32'h410, 32'd0);
        push_beat(1'b0, 32'h414, 32'd0);
        push_beat(1'b1, 32'h510, 32'd5);
        push_beat(1'b1, 32'h514, 32'd6);
        done_q.push_back(-1);
        start(32'h400, 32'h500, 16'd6, e);
        wait_idle(200);
        tick();
        chk("gap_mem_510", mem[32'h510 >> 2], 32'd5);
        chk("gap_mem_514", mem[32'h514 >> 2], 32'd6);
        chk("gap_irq", {31'd0, irq}, 32'd1);
        clear_irq();

        // len = 0 with irq_clr on the same edge as the set.
        gmode = 0;
        tick();
        req_seen = 1'b0;
        start(32'h400, 32'h500, 16'd0, e);
        done_q.push_back(e);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("len0_irq_set_wins", {31'd0, irq}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        chk("len0_no_req", {31'd0, req_seen}, 32'd0);
        clear_irq();

        // Misaligned source, then an aligned start clears err.
        req_seen = 1'b0;
        start(32'h402, 32'h500, 16'd4, e);
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_irq", {31'd0, irq}, 32'd1);
        chk("mis_busy", {31'd0, busy}, 32'd0);
        tick(); tick(); tick();
        chk("mis_no_req", {31'd0, req_seen}, 32'd0);
        chk("mis_err_sticky", {31'd0, err}, 32'd1);
        clear_irq();
        push_beat(1'b0, 32'h400, 32'd0);
        push_beat(1'b1, 32'h600, 32'd1);
        start(32'h400, 32'h600, 16'd1, e);
        done_q.push_back(e + 2);
        chk("mis_err_cleared", {31'd0, err}, 32'd0);
        wait_idle(50);
        tick();
        clear_irq();

        // Abort during the second write beat; a start while busy is ignored.
        for (int i = 0; i < 4; i++) poke(32'h500 + 32'(4 * i), 32'hDEAD_0000);
        for (int i = 0; i < 4; i++) push_beat(1'b0, 32'h400 + 32'(4 * i), 32'd0);
        push_beat(1'b1, 32'h500, 32'd1);
        push_beat(1'b1, 32'h504, 32'd2);
        start(32'h400, 32'h500, 16'd4, e);
        tick();
        cfg_src = 32'h700; cfg_dst = 32'h780; cfg_len = 16'd1; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        while (cyc < e + 5) tick();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        tick(); tick();
        chk("abort_no_irq", {31'd0, irq}, 32'd0);
        chk("abort_mem_500", mem[32'h500 >> 2], 32'd1);
        chk("abort_mem_504", mem[32'h504 >> 2], 32'd2);
        chk("abort_mem_508", mem[32'h508 >> 2], 32'hDEAD_0000);
        chk("abort_mem_50c", mem[32'h50C >> 2], 32'hDEAD_0000);

        // Reset while stalled in RD, then a fresh len=1 copy.
        gmode = 2;
        tick();
        start(32'h400, 32'h500, 16'd4, e);
        tick();
        chk("mid_rd_req", {31'd0, dma_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        chk("mid_rst_req", {31'd0, dma_req}, 32'd0);
        chk("mid_rst_we", {31'd0, dma_we}, 32'd0);
        chk("mid_rst_addr", dma_addr, 32'd0);
        chk("mid_rst_wdata", dma_wdata, 32'd0);
        tick();
        rst_n = 1'b1;
        gmode = 0;
        tick();
        tick();
        push_beat(1'b0, 32'h40C, 32'd0);
        push_beat(1'b1, 32'h600, 32'd4);
        start(32'h40C, 32'h600, 16'd1, e);
        done_q.push_back(e + 2);
        wait_idle(50);
        tick();
        chk("post_rst_irq", {31'd0, irq}, 32'd1);
        chk("post_rst_mem", mem[32'h600 >> 2], 32'd4);
        clear_irq();

        tick();
        chk("beats_left", exp_q.size(), 32'd0);
        chk("dones_left", done_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
